// File: rtl/object_drawer.sv
// object_drawer: reads every word of a sprite ROM and issues one VGA plot
// per pixel, offset by the latched object origin. A two-stage pipeline
// covers the one-cycle ROM latency: the address stage issues addr_cnt, and
// the output stage pairs the returned colour with the address it came from.
module object_drawer #(
   parameter int n          = 3,
   parameter int Mn         = 6,
   parameter int COL_BITS   = 3,
   parameter int XW         = 8,
   parameter int YW         = 7,
   parameter int SKIP_TRANS = 1,
   parameter int TRANS_COL  = 0
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          start,
   input  logic [XW-1:0] obj_x,
   input  logic [YW-1:0] obj_y,
   output logic          busy,
   output logic          done,
   output logic [Mn-1:0] rom_address,
   input  logic [n-1:0]  rom_q,
   output logic [XW-1:0] vga_x,
   output logic [YW-1:0] vga_y,
   output logic [n-1:0]  vga_colour,
   output logic          vga_plot
);

   localparam logic [Mn-1:0] LAST_ADDR = {Mn{1'b1}};
   localparam logic [n-1:0]  TRANS_V   = n'(TRANS_COL);
   localparam bit            SKIP_EN   = (SKIP_TRANS != 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic          accept_s;
   logic          issue_s;
   logic          finish_s;

   logic [XW-1:0] ox_r;
   logic [YW-1:0] oy_r;
   logic [Mn-1:0] addr_cnt_r;
   logic [Mn-1:0] pipe_addr_r;
   logic          pipe_valid_r;
   logic          busy_r;
   logic          done_r;
   logic [XW-1:0] vga_x_r;
   logic [YW-1:0] vga_y_r;
   logic [n-1:0]  vga_colour_r;
   logic          vga_plot_r;
   logic          opaque_s;

   // State register for the draw sequencer.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic and per-cycle control strobes.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      issue_s     = 1'b0;
      finish_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               accept_s    = 1'b1;
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            issue_s = 1'b1;
            if (addr_cnt_r == LAST_ADDR) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // The final pixel leaves the output stage on this edge.
            finish_s    = 1'b1;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Origin latch, address counter, address pipeline and busy/done flags.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ox_r         <= {XW{1'b0}};
         oy_r         <= {YW{1'b0}};
         addr_cnt_r   <= {Mn{1'b0}};
         pipe_addr_r  <= {Mn{1'b0}};
         pipe_valid_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         done_r <= finish_s;
         if (accept_s) begin
            ox_r       <= obj_x;
            oy_r       <= obj_y;
            addr_cnt_r <= {Mn{1'b0}};
            busy_r     <= 1'b1;
         end else if (finish_s) begin
            busy_r <= 1'b0;
         end else begin
            busy_r <= busy_r;
         end
         if (issue_s) begin
            pipe_addr_r  <= addr_cnt_r;
            pipe_valid_r <= 1'b1;
            // Hold on the last address rather than wrapping.
            if (addr_cnt_r != LAST_ADDR) begin
               addr_cnt_r <= addr_cnt_r + {{(Mn-1){1'b0}}, 1'b1};
            end else begin
               addr_cnt_r <= addr_cnt_r;
            end
         end else begin
            pipe_valid_r <= 1'b0;
         end
      end
   end

   // Transparent pixels still take their slot but do not strobe the adapter.
   always_comb begin
      opaque_s = 1'b1;
      if (SKIP_EN && (rom_q == TRANS_V)) begin
         opaque_s = 1'b0;
      end else begin
         opaque_s = 1'b1;
      end
   end

   // Output stage: pair ROM data with its address; coordinates wrap on overflow.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         vga_x_r      <= {XW{1'b0}};
         vga_y_r      <= {YW{1'b0}};
         vga_colour_r <= {n{1'b0}};
         vga_plot_r   <= 1'b0;
      end else if (pipe_valid_r) begin
         vga_x_r      <= ox_r + XW'(pipe_addr_r[COL_BITS-1:0]);
         vga_y_r      <= oy_r + YW'(pipe_addr_r[Mn-1:COL_BITS]);
         vga_colour_r <= rom_q;
         vga_plot_r   <= opaque_s;
      end else begin
         vga_plot_r <= 1'b0;
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign rom_address = addr_cnt_r;
   assign vga_x       = vga_x_r;
   assign vga_y       = vga_y_r;
   assign vga_colour  = vga_colour_r;
   assign vga_plot    = vga_plot_r;

endmodule

// File: tb/tb_object_drawer.sv
// Directed bench for object_drawer. Two instances share all stimulus: one
// plots every pixel, the other skips colour 0. Each has its own registered
// ROM model holding ROM[a] = a % 8.
module tb_object_drawer;

   logic       clock = 1'b0;
   logic       resetn;
   logic       start;
   logic [7:0] obj_x;
   logic [6:0] obj_y;

   logic       busy_o, done_o, plot_o;
   logic [5:0] addr_o;
   logic [2:0] q_o, col_o;
   logic [7:0] x_o;
   logic [6:0] y_o;

   logic       busy_t, done_t, plot_t;
   logic [5:0] addr_t;
   logic [2:0] q_t, col_t;
   logic [7:0] x_t;
   logic [6:0] y_t;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   object_drawer #(.SKIP_TRANS(0)) u_opaque (
      .clock(clock), .resetn(resetn), .start(start), .obj_x(obj_x), .obj_y(obj_y),
      .busy(busy_o), .done(done_o), .rom_address(addr_o), .rom_q(q_o),
      .vga_x(x_o), .vga_y(y_o), .vga_colour(col_o), .vga_plot(plot_o)
   );

   object_drawer #(.SKIP_TRANS(1)) u_trans (
      .clock(clock), .resetn(resetn), .start(start), .obj_x(obj_x), .obj_y(obj_y),
      .busy(busy_t), .done(done_t), .rom_address(addr_t), .rom_q(q_t),
      .vga_x(x_t), .vga_y(y_t), .vga_colour(col_t), .vga_plot(plot_t)
   );

   // ROM models: registered address, one-cycle latency, ROM[a] = a % 8.
   always @(posedge clock) begin
      q_o <= addr_o[2:0];
      q_t <= addr_t[2:0];
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_plot_o"}, 32'(plot_o), 32'd0);
      check_eq({tag, "_plot_t"}, 32'(plot_t), 32'd0);
      check_eq({tag, "_done"},   32'(done_o), 32'd0);
      check_eq({tag, "_busy"},   32'(busy_o), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_quiet(tag);
      check_eq({tag, "_x"},    32'(x_o),    32'd0);
      check_eq({tag, "_y"},    32'(y_o),    32'd0);
      check_eq({tag, "_col"},  32'(col_o),  32'd0);
      check_eq({tag, "_addr"}, 32'(addr_o), 32'd0);
      check_eq({tag, "_busy_t"}, 32'(busy_t), 32'd0);
      check_eq({tag, "_done_t"}, 32'(done_t), 32'd0);
   endtask

   // Called at a negedge: start is accepted at the next posedge (E0). Checks
   // every cycle E1..E65 and returns at the negedge after E65 with start low.
   // poke=1 re-pulses start (new origin 200,100) at E10 and at E65.
   task automatic run_draw(input string tag, input logic [7:0] ox, input logic [6:0] oy,
                           input bit poke);
      int p;
      bit exp_plot;
      start = 1'b1;
      obj_x = ox;
      obj_y = oy;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      obj_x = ox + 8'd37;
      obj_y = oy + 7'd11;
      for (int k = 1; k <= 65; k++) begin
         @(posedge clock);
         @(negedge clock);
         p = k - 2;
         exp_plot = (k >= 2);
         check_eq($sformatf("%s_busy_E%0d", tag, k), 32'(busy_o), 32'(k <= 64));
         check_eq($sformatf("%s_done_E%0d", tag, k), 32'(done_o), 32'(k == 65));
         check_eq($sformatf("%s_done_t_E%0d", tag, k), 32'(done_t), 32'(k == 65));
         check_eq($sformatf("%s_plot_o_E%0d", tag, k), 32'(plot_o), 32'(exp_plot));
         check_eq($sformatf("%s_plot_t_E%0d", tag, k), 32'(plot_t),
                  32'(exp_plot && (p % 8 != 0)));
         if (exp_plot) begin
            check_eq($sformatf("%s_x_E%0d", tag, k), 32'(x_o), (32'(ox) + 32'(p % 8)) % 256);
            check_eq($sformatf("%s_y_E%0d", tag, k), 32'(y_o), (32'(oy) + 32'(p / 8)) % 128);
            check_eq($sformatf("%s_col_E%0d", tag, k), 32'(col_o), 32'(p % 8));
         end
         start = poke && ((k + 1 == 10) || (k + 1 == 65));
         if (poke) begin
            obj_x = 8'd200;
            obj_y = 7'd100;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      // 1: reset with start held high
      resetn = 1'b0;
      start  = 1'b1;
      obj_x  = 8'd55;
      obj_y  = 7'd33;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_all_zero("rst");
      start  = 1'b0;
      resetn = 1'b1;
      repeat (3) begin
         @(posedge clock);
         @(negedge clock);
         check_quiet("post_rst");
      end

      // 2 and 3: full draw at (10,20) on both instances
      run_draw("full", 8'd10, 7'd20, 1'b0);
      @(posedge clock);
      @(negedge clock);
      check_quiet("full_after");

      // 4: coordinate wrap, last pixel lands at (3,4)
      run_draw("wrap", 8'd252, 7'd125, 1'b0);
      check_eq("wrap_x_last", 32'(x_o), 32'd3);
      check_eq("wrap_y_last", 32'(y_o), 32'd4);
      @(posedge clock);
      @(negedge clock);
      check_quiet("wrap_after");

      // 5: starts at E10 and on the done edge ignored; next cycle accepted
      run_draw("ign", 8'd1, 7'd2, 1'b1);
      run_draw("chain", 8'd30, 7'd40, 1'b0);
      @(posedge clock);
      @(negedge clock);
      check_quiet("chain_after");

      // 6: asynchronous abort mid-draw
      start = 1'b1;
      obj_x = 8'd5;
      obj_y = 7'd6;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (30) @(posedge clock);
      #2;
      resetn = 1'b0;
      #1;
      check_all_zero("abort");
      repeat (4) begin
         @(posedge clock);
         @(negedge clock);
         check_all_zero("abort_hold");
      end
      resetn = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_quiet("abort_rel");
      run_draw("fresh", 8'd100, 7'd50, 1'b0);
      @(posedge clock);
      @(negedge clock);
      check_quiet("fresh_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
